// File: rtl/rx_mac_filter_pkg.sv
// Shared types and constants for the RX MAC address filter.
//   state_t        : frame-tracking FSM states
//   BCAST_MAC      : broadcast destination address
//   RUNT_KEEP_MASK : tkeep bits that must all be set on a first beat (full DA)
//   wire_to_mac()  : reorders the first six wire bytes into a 48-bit MAC value
package rx_mac_filter_pkg;

   typedef enum logic [1:0] {
      ST_FIRST = 2'd0,
      ST_PASS  = 2'd1,
      ST_DROP  = 2'd2
   } state_t;

   localparam logic [47:0] BCAST_MAC      = 48'hFFFF_FFFF_FFFF;
   localparam logic [5:0]  RUNT_KEEP_MASK = 6'h3F;

   // Wire byte 0 (tdata[7:0]) is the most significant MAC byte.
   function automatic logic [47:0] wire_to_mac(input logic [47:0] lo);
      logic [47:0] mac;
      for (int i = 0; i < 6; i++) begin
         mac[47-8*i -: 8] = lo[8*i +: 8];
      end
      return mac;
   endfunction

endpackage

// File: rtl/rx_mac_filter_if.sv
// AXI4-Stream beat interface (64-bit data, 8-bit keep, last, user).
//   master : drives tdata/tkeep/tvalid/tlast/tuser, receives tready
//   slave  : receives tdata/tkeep/tvalid/tlast/tuser, drives tready
interface rx_mac_filter_if;
   logic [63:0] tdata;
   logic [7:0]  tkeep;
   logic        tvalid;
   logic        tlast;
   logic        tuser;
   logic        tready;

   modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
   modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/rx_mac_filter_axis_out_reg.sv
// 1-deep AXI4-Stream output register (data, keep, last, user).
//   clk156, reset : clock, synchronous active-high reset
//   in_*          : beat to load, in_valid qualifies it
//   in_ready      : register can take a beat this cycle (empty or draining)
//   m_axis        : registered output stream
module axis_out_reg (
   input  logic                   clk156,
   input  logic                   reset,
   input  logic                   in_valid,
   input  logic [63:0]            in_tdata,
   input  logic [7:0]             in_tkeep,
   input  logic                   in_tlast,
   input  logic                   in_tuser,
   output logic                   in_ready,
   rx_mac_filter_if.master        m_axis
);

   logic        valid_q, valid_d;
   logic [63:0] tdata_q, tdata_d;
   logic [7:0]  tkeep_q, tkeep_d;
   logic        tlast_q, tlast_d;
   logic        tuser_q, tuser_d;

   always_comb begin
      in_ready = !valid_q || m_axis.tready;
      valid_d  = valid_q;
      tdata_d  = tdata_q;
      tkeep_d  = tkeep_q;
      tlast_d  = tlast_q;
      tuser_d  = tuser_q;
      if (in_valid && in_ready) begin
         valid_d = 1'b1;
         tdata_d = in_tdata;
         tkeep_d = in_tkeep;
         tlast_d = in_tlast;
         tuser_d = in_tuser;
      end else if (m_axis.tready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk156) begin
      if (reset) begin
         valid_q <= 1'b0;
         tdata_q <= '0;
         tkeep_q <= '0;
         tlast_q <= 1'b0;
         tuser_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
         tdata_q <= tdata_d;
         tkeep_q <= tkeep_d;
         tlast_q <= tlast_d;
         tuser_q <= tuser_d;
      end
   end

   assign m_axis.tvalid = valid_q;
   assign m_axis.tdata  = tdata_q;
   assign m_axis.tkeep  = tkeep_q;
   assign m_axis.tlast  = tlast_q;
   assign m_axis.tuser  = tuser_q;

endmodule

// File: rtl/rx_mac_filter.sv
// RX MAC destination-address filter with pass/drop frame counters.
//   clk156, reset            : clock, synchronous active-high reset
//   s_axis                   : incoming frame stream
//   m_axis                   : filtered frame stream (1-cycle registered)
//   my_mac/promisc_en/mcast_en : filter config, sampled on each first beat
//   pkts_passed/pkts_dropped : saturating frame counters
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_FIRST | next accepted beat starts a frame; decision made from it
// ST_PASS  | mid-frame, beats forwarded to the output register
// ST_DROP  | mid-frame, beats consumed and discarded
module rx_mac_filter
   import rx_mac_filter_pkg::*;
#(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk156,
   input  logic                 reset,
   rx_mac_filter_if.slave       s_axis,
   rx_mac_filter_if.master      m_axis,
   input  logic [47:0]          my_mac,
   input  logic                 promisc_en,
   input  logic                 mcast_en,
   output logic [CNT_WIDTH-1:0] pkts_passed,
   output logic [CNT_WIDTH-1:0] pkts_dropped
);

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] passed_q, passed_d;
   logic [CNT_WIDTH-1:0] dropped_q, dropped_d;

   logic [47:0] da;
   logic        runt;
   logic        pass_dec;
   logic        fwd;
   logic        hs;
   logic        out_ready;
   logic        out_valid;

   // Decision and handshake. Only forwarded beats see output backpressure;
   // dropped beats are always accepted.
   always_comb begin
      da       = wire_to_mac(s_axis.tdata[47:0]);
      runt     = s_axis.tkeep[5:0] != RUNT_KEEP_MASK;
      pass_dec = !runt && (promisc_en || (da == my_mac) || (da == BCAST_MAC) ||
                           (mcast_en && s_axis.tdata[0]));
      fwd      = (state_q == ST_FIRST) ? pass_dec : (state_q == ST_PASS);
      s_axis.tready = 1'b0;
      if (!reset) begin
         s_axis.tready = fwd ? out_ready : 1'b1;
      end
      hs        = s_axis.tvalid && s_axis.tready;
      out_valid = hs && fwd;
   end

   always_comb begin
      state_d   = state_q;
      passed_d  = passed_q;
      dropped_d = dropped_q;
      unique case (state_q)
         ST_FIRST: begin
            if (hs) begin
               if (!s_axis.tlast) begin
                  state_d = pass_dec ? ST_PASS : ST_DROP;
               end
               if (pass_dec) begin
                  if (passed_q != '1) passed_d = passed_q + 1'b1;
               end else begin
                  if (dropped_q != '1) dropped_d = dropped_q + 1'b1;
               end
            end
         end
         ST_PASS, ST_DROP: begin
            if (hs && s_axis.tlast) state_d = ST_FIRST;
         end
         default: state_d = ST_FIRST;
      endcase
   end

   always_ff @(posedge clk156) begin
      if (reset) begin
         state_q   <= ST_FIRST;
         passed_q  <= '0;
         dropped_q <= '0;
      end else begin
         state_q   <= state_d;
         passed_q  <= passed_d;
         dropped_q <= dropped_d;
      end
   end

   assign pkts_passed  = passed_q;
   assign pkts_dropped = dropped_q;

   axis_out_reg u_out_reg (
      .clk156   (clk156),
      .reset    (reset),
      .in_valid (out_valid),
      .in_tdata (s_axis.tdata),
      .in_tkeep (s_axis.tkeep),
      .in_tlast (s_axis.tlast),
      .in_tuser (s_axis.tuser),
      .in_ready (out_ready),
      .m_axis   (m_axis)
   );

endmodule

// File: tb/tb_rx_mac_filter.sv
module tb_rx_mac_filter;

   localparam int CW   = 5;
   localparam int CMAX = 31;

   logic          clk156 = 1'b0;
   logic          reset  = 1'b1;
   logic [47:0]   my_mac;
   logic          promisc_en;
   logic          mcast_en;
   logic [CW-1:0] pkts_passed;
   logic [CW-1:0] pkts_dropped;

   always #5 clk156 = ~clk156;

   rx_mac_filter_if s_if ();
   rx_mac_filter_if m_if ();

   rx_mac_filter #(.CNT_WIDTH(CW)) dut (
      .clk156       (clk156),
      .reset        (reset),
      .s_axis       (s_if),
      .m_axis       (m_if),
      .my_mac       (my_mac),
      .promisc_en   (promisc_en),
      .mcast_en     (mcast_en),
      .pkts_passed  (pkts_passed),
      .pkts_dropped (pkts_dropped)
   );

   typedef struct packed {
      logic [63:0] d;
      logic [7:0]  k;
      logic        l;
      logic        u;
   } beat_t;

   beat_t exp_q[$];
   int    n_vec    = 0;
   int    n_err    = 0;
   int    exp_pass = 0;
   int    exp_drop = 0;
   int    bp_mode  = 0;

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference filter rule, evaluated byte by byte on the wire order.
   function automatic bit model_pass(input logic [63:0] d, input logic [7:0] k,
                                     input logic [47:0] mac, input bit prom, input bit mc);
      bit runt = 0;
      bit uni  = 1;
      bit bc   = 1;
      logic [7:0] b;
      for (int i = 0; i < 6; i++) begin
         b = d[8*i +: 8];
         if (!k[i]) runt = 1;
         if (b != mac[8*(5-i) +: 8]) uni = 0;
         if (b != 8'hFF) bc = 0;
      end
      if (runt) return 0;
      return prom || uni || bc || (mc && d[0]);
   endfunction

   // Downstream ready: 0 = always 1, 1 = random, 2 = repeating 1,0,0,1.
   initial begin
      int pi = 0;
      m_if.tready = 1'b1;
      forever begin
         @(posedge clk156);
         #1;
         case (bp_mode)
            1: m_if.tready = 1'($urandom_range(0, 1));
            2: begin
               m_if.tready = (pi == 0 || pi == 3);
               pi = (pi + 1) % 4;
            end
            default: m_if.tready = 1'b1;
         endcase
      end
   end

   // Output monitor / scoreboard.
   initial begin
      bit          stall_prev = 0;
      logic [73:0] held;
      logic [73:0] cur;
      beat_t       e;
      forever begin
         @(negedge clk156);
         cur = {m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser};
         if (stall_prev) check("stall_hold", 80'({m_if.tvalid, cur}), 80'({1'b1, held}));
         if (m_if.tvalid && m_if.tready) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_beat: got %h expected none", cur);
            end else begin
               e = exp_q.pop_front();
               check("out_beat", 80'(cur), 80'(e));
            end
         end
         stall_prev = !reset && m_if.tvalid && !m_if.tready;
         held       = cur;
      end
   end

   task automatic send_beat(input beat_t b, input bit chk_rdy, input bit chk_lat);
      bit hs = 0;
      int t  = 0;
      s_if.tdata  = b.d;
      s_if.tkeep  = b.k;
      s_if.tlast  = b.l;
      s_if.tuser  = b.u;
      s_if.tvalid = 1'b1;
      while (!hs) begin
         @(negedge clk156);
         hs = s_if.tready;
         if (chk_rdy) check("drop_tready", 80'(s_if.tready), 80'(1));
         @(posedge clk156);
         #1;
         t++;
         if (!hs && t > 200) begin
            $display("FAIL hs_timeout: got no tready expected handshake");
            n_err++;
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
            $fatal(1, "handshake timeout");
         end
      end
      s_if.tvalid = 1'b0;
      if (chk_lat) begin
         @(negedge clk156);
         check("lat1_valid", 80'(m_if.tvalid), 80'(1));
         check("lat1_data", 80'(m_if.tdata), 80'(b.d));
         @(posedge clk156);
         #1;
      end
   endtask

   task automatic send_frame(input int nb, input logic [47:0] da, input logic [7:0] k0,
                             input bit churn, input bit chk_rdy, input bit chk_lat);
      beat_t bts[$];
      beat_t b;
      bit    pass;
      for (int i = 0; i < nb; i++) begin
         b.d = {$urandom, $urandom};
         b.k = (i == nb - 1) ? (8'($urandom) | 8'h01) : 8'hFF;
         b.l = (i == nb - 1);
         b.u = 1'($urandom_range(0, 1));
         if (i == 0) begin
            for (int j = 0; j < 6; j++) b.d[8*j +: 8] = da[8*(5-j) +: 8];
            b.k = k0;
         end
         bts.push_back(b);
      end
      pass = model_pass(bts[0].d, bts[0].k, my_mac, promisc_en, mcast_en);
      if (pass) begin
         foreach (bts[i]) exp_q.push_back(bts[i]);
         if (exp_pass < CMAX) exp_pass++;
      end else begin
         if (exp_drop < CMAX) exp_drop++;
      end
      foreach (bts[i]) begin
         send_beat(bts[i], chk_rdy, chk_lat);
         if (i == 0 && churn) begin
            promisc_en = 1'($urandom_range(0, 1));
            mcast_en   = 1'($urandom_range(0, 1));
            my_mac     = {16'($urandom), 32'($urandom)};
         end
      end
      @(negedge clk156);
      check("pkts_passed", 80'(pkts_passed), 80'(exp_pass));
      check("pkts_dropped", 80'(pkts_dropped), 80'(exp_drop));
      @(posedge clk156);
      #1;
   endtask

   initial begin
      beat_t       b;
      logic [47:0] da;
      logic [7:0]  k0;
      int          kind;
      int          t;

      s_if.tvalid = 1'b0;
      s_if.tdata  = '0;
      s_if.tkeep  = '0;
      s_if.tlast  = 1'b0;
      s_if.tuser  = 1'b0;
      my_mac      = 48'h000A_3501_0203;
      promisc_en  = 1'b0;
      mcast_en    = 1'b0;

      repeat (3) @(posedge clk156);
      @(negedge clk156);
      check("rst_s_tready", 80'(s_if.tready), 80'(0));
      check("rst_m_tvalid", 80'(m_if.tvalid), 80'(0));
      check("rst_m_beat", 80'({m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser}), 80'(0));
      check("rst_passed", 80'(pkts_passed), 80'(0));
      check("rst_dropped", 80'(pkts_dropped), 80'(0));
      @(posedge clk156);
      #1;
      reset = 1'b0;

      // Unicast match, 3 beats, latency 1
      send_frame(3, 48'h000A_3501_0203, 8'hFF, 0, 0, 1);
      // Mismatch drop, 4 beats, always ready
      send_frame(4, 48'h000A_3501_0204, 8'hFF, 0, 1, 0);
      // Broadcast, then multicast off/on
      send_frame(2, 48'hFFFF_FFFF_FFFF, 8'hFF, 0, 0, 0);
      send_frame(2, 48'h0100_5E00_0001, 8'hFF, 0, 1, 0);
      mcast_en = 1'b1;
      send_frame(2, 48'h0100_5E00_0001, 8'hFF, 0, 0, 0);
      mcast_en = 1'b0;
      // Backpressure 1,0,0,1 over a 5-beat passing frame
      bp_mode = 2;
      send_frame(5, 48'h000A_3501_0203, 8'hFF, 0, 0, 0);
      bp_mode = 0;
      repeat (4) @(posedge clk156);
      #1;
      // Runt with promiscuous mode
      promisc_en = 1'b1;
      send_frame(1, 48'h000A_3501_0203, 8'h0F, 0, 1, 0);
      promisc_en = 1'b0;

      // Reset during beat 2 of a passing frame
      b.d = {$urandom, $urandom};
      for (int j = 0; j < 6; j++) b.d[8*j +: 8] = my_mac[8*(5-j) +: 8];
      b.k = 8'hFF;
      b.l = 1'b0;
      b.u = 1'b1;
      exp_q.push_back(b);
      send_beat(b, 0, 0);
      s_if.tdata  = {$urandom, $urandom};
      s_if.tlast  = 1'b0;
      s_if.tvalid = 1'b1;
      reset       = 1'b1;
      @(negedge clk156);
      check("rst_mid_tready", 80'(s_if.tready), 80'(0));
      @(posedge clk156);
      #1;
      reset       = 1'b0;
      s_if.tvalid = 1'b0;
      exp_pass    = 0;
      exp_drop    = 0;
      @(negedge clk156);
      check("rst_mid_mvalid", 80'(m_if.tvalid), 80'(0));
      @(posedge clk156);
      #1;
      send_frame(1, 48'h000A_3501_0299, 8'hFF, 0, 1, 0);

      // Randomized frames with mid-frame config churn and random backpressure
      bp_mode = 1;
      for (int f = 0; f < 60; f++) begin
         kind = $urandom_range(0, 4);
         da   = {16'($urandom), 32'($urandom)};
         k0   = 8'hFF;
         case (kind)
            0: da = my_mac;
            1: da = 48'hFFFF_FFFF_FFFF;
            2: da[40] = 1'b1;
            3: da[40] = 1'b0;
            default: begin
               da = my_mac;
               k0 = (8'($urandom) & 8'hDF) | 8'h01;
            end
         endcase
         send_frame($urandom_range(1, 6), da, k0, 1, 0, 0);
      end
      bp_mode    = 0;
      promisc_en = 1'b0;
      mcast_en   = 1'b0;
      my_mac     = 48'h000A_3501_0203;

      // Saturation of both counters
      for (int f = 0; f < CMAX + 2; f++) begin
         send_frame(1, 48'hFFFF_FFFF_FFFF, 8'hFF, 0, 0, 0);
         send_frame(1, 48'h0200_0000_0001, 8'hFF, 0, 0, 0);
      end
      check("sat_passed", 80'(pkts_passed), 80'(CMAX));
      check("sat_dropped", 80'(pkts_dropped), 80'(CMAX));

      t = 0;
      while (exp_q.size() != 0 && t < 100) begin
         @(posedge clk156);
         t++;
      end
      @(negedge clk156);
      check("drain", 80'(exp_q.size()), 80'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
